// File: rtl/mem_responder.sv
// Data-side memory responder: accepts MEM-stage load/store requests, checks width and
// alignment, and answers from a byte-lane RAM after WAIT_CYCLES wait states.

module mem_lane #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);
  logic [7:0] ram [2**ADDR_BITS];

  always_ff @(posedge clk) if (we) ram[addr] <= wdata;
  assign rdata = ram[addr];
endmodule

module mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_width,
  input  logic        req_zext,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [2:0]  resp_exception
);
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        zext;
  } mem_req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                         state, state_n;
  logic [1:0]                     cnt;
  mem_req_t                       req_in, lat, cur;
  logic                           accept, fire;
  logic [2:0]                     exc;
  logic [29:0]                    word_idx;
  logic [NUM_LANES-1:0]           be, we;
  logic [NUM_LANES-1:0][7:0]      lane_wdata, lane_rdata;
  logic [31:0]                    wrep, shifted, ext;

  assign req_ready = (state != WAIT) && !rst;
  assign accept    = req_valid && req_ready;
  assign req_in    = {req_write, req_addr, req_wdata, req_width, req_zext};

  // With no wait states the request is serviced on its own accept edge, straight from the ports.
  assign cur  = (WAIT_CYCLES == 0) ? req_in : lat;
  assign fire = !rst && ((state == WAIT && cnt == 2'd1) || (WAIT_CYCLES == 0 && accept));

  always_comb begin
    state_n = state;
    case (state)
      IDLE, RESP: state_n = accept ? ((WAIT_CYCLES == 0) ? RESP : WAIT) : IDLE;
      WAIT:       if (cnt == 2'd1) state_n = RESP;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (accept)             cnt <= 2'(WAIT_CYCLES);
      else if (state == WAIT) cnt <= cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) if (accept) lat <= req_in;

  assign word_idx = cur.addr[31:2];

  always_comb begin
    exc = 3'd0;
    if (cur.width == 2'd3)
      exc = 3'd3;
    else if ((cur.width == 2'd1 && cur.addr[0]) || (cur.width == 2'd2 && cur.addr[1:0] != 2'b00))
      exc = 3'd1;
    else if ((word_idx >> ADDR_BITS) != 30'd0)
      exc = 3'd2;
  end

  always_comb begin
    be   = 4'b1111;
    wrep = cur.wdata;
    case (cur.width)
      2'd0: begin
        be   = 4'b0001 << cur.addr[1:0];
        wrep = {4{cur.wdata[7:0]}};
      end
      2'd1: begin
        be   = cur.addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{cur.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign we[i]         = fire && cur.write && (exc == 3'd0) && be[i];
    assign lane_wdata[i] = wrep[8*i +: 8];
    mem_lane #(.ADDR_BITS(ADDR_BITS)) u_lane (
      .clk  (clk),
      .we   (we[i]),
      .addr (word_idx[ADDR_BITS-1:0]),
      .wdata(lane_wdata[i]),
      .rdata(lane_rdata[i])
    );
  end

  assign shifted = lane_rdata >> {cur.addr[1:0], 3'b000};

  always_comb begin
    ext = lane_rdata;
    case (cur.width)
      2'd0:    ext = cur.zext ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    ext = cur.zext ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_exception <= '0;
    end else begin
      resp_valid     <= fire;
      resp_exception <= fire ? exc : 3'd0;
      resp_rdata     <= (fire && exc == 3'd0 && !cur.write) ? ext : 32'd0;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (0 and 2 wait states), byte-array reference model,
// scoreboard queues popped by a negedge monitor.

module tb_mem_responder;
  localparam int AB   = 10;
  localparam int NDUT = 2;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  exc;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst            [NDUT];
  logic        req_valid      [NDUT];
  logic        req_ready      [NDUT];
  logic        req_write      [NDUT];
  logic [31:0] req_addr       [NDUT];
  logic [31:0] req_wdata      [NDUT];
  logic [1:0]  req_width      [NDUT];
  logic        req_zext       [NDUT];
  logic        resp_valid     [NDUT];
  logic [31:0] resp_rdata     [NDUT];
  logic [2:0]  resp_exception [NDUT];

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [7:0]  bmem [NDUT][4*(1<<AB)];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(2*g)) dut (
      .clk           (clk),
      .rst           (rst[g]),
      .req_valid     (req_valid[g]),
      .req_ready     (req_ready[g]),
      .req_write     (req_write[g]),
      .req_addr      (req_addr[g]),
      .req_wdata     (req_wdata[g]),
      .req_width     (req_width[g]),
      .req_zext      (req_zext[g]),
      .resp_valid    (resp_valid[g]),
      .resp_rdata    (resp_rdata[g]),
      .resp_exception(resp_exception[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: byte-addressed memory, faults by plain arithmetic on size and address.
  task automatic model(input int k, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] w, input bit z,
                       output logic [31:0] rd, output logic [2:0] ex);
    int nb;
    logic [31:0] v;
    rd = 32'd0;
    ex = 3'd0;
    nb = 1 << w;
    if (w == 2'd3) ex = 3'd3;
    else if (a % nb != 0) ex = 3'd1;
    else if (a / 4 >= (1 << AB)) ex = 3'd2;
    else if (wr) begin
      for (int i = 0; i < nb; i++) bmem[k][a+i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(bmem[k][a+i]) << (8*i));
      if (nb < 4 && !z && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8*nb));
      rd = v;
    end
  endtask

  // Drives a request from just after a posedge; returns #1 after its accept edge.
  task automatic issue(input int k, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] w, input bit z, input bit track,
                       output int unsigned acc);
    exp_t e;
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    req_width[k] = w;
    req_zext[k]  = z;
    acc = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[k] === 1'b1) begin
        acc = cyc;
        if (track) begin
          model(k, wr, a, wd, w, z, e.rdata, e.exc);
          e.cyc = cyc + 1 + 2*k;
          if (k == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    total++;
    bad++;
    $display("FAIL accept_timeout dut%0d addr %h", k, a);
    req_valid[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      exp_t e;
      if (resp_valid[k] === 1'b1) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp dut%0d: got resp_valid=1 want 0 (cycle %0d)", k, cyc);
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("dut%0d_resp_cycle", k), cyc, e.cyc);
          chk($sformatf("dut%0d_rdata", k), resp_rdata[k], e.rdata);
          chk($sformatf("dut%0d_exception", k), 32'(resp_exception[k]), 32'(e.exc));
        end
      end else if (rst[k] === 1'b0) begin
        chk($sformatf("dut%0d_idle_rdata", k), resp_rdata[k], 32'd0);
        chk($sformatf("dut%0d_idle_exc", k), 32'(resp_exception[k]), 32'd0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t1, t2;
    logic [31:0] a;
    logic [1:0]  w;
    for (int k = 0; k < NDUT; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_width[k] = '0; req_zext[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("dut%0d_rst_ready", k), 32'(req_ready[k]), 32'd0);
      chk($sformatf("dut%0d_rst_valid", k), 32'(resp_valid[k]), 32'd0);
      chk($sformatf("dut%0d_rst_rdata", k), resp_rdata[k], 32'd0);
      chk($sformatf("dut%0d_rst_exc", k), 32'(resp_exception[k]), 32'd0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) chk($sformatf("dut%0d_ready_after_rst", k), 32'(req_ready[k]), 32'd1);
    @(posedge clk); #1;

    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 16; i++) issue(k, 1'b1, 32'(4*i), $urandom, 2'd2, 1'b0, 1'b1, t1);

      issue(k, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1, t1);
      issue(k, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 1'b1, t2);
      if (k == 0) chk("dut0_back_to_back_accept", t2, t1 + 1);
      for (int z = 0; z < 2; z++)
        for (int b = 0; b < 4; b++) issue(k, 1'b0, 32'h10 + 32'(b), 32'd0, 2'd0, z[0], 1'b1, t1);
      issue(k, 1'b1, 32'h12, 32'h1234, 2'd1, 1'b0, 1'b1, t1);
      issue(k, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 1'b1, t1);
      issue(k, 1'b0, 32'h11, 32'd0, 2'd2, 1'b0, 1'b1, t1);
      issue(k, 1'b0, 32'h11, 32'd0, 2'd3, 1'b0, 1'b1, t1);
      issue(k, 1'b0, 32'((1 << AB) * 4), 32'd0, 2'd2, 1'b0, 1'b1, t1);
      issue(k, 1'b1, 32'h11, 32'h5555AAAA, 2'd2, 1'b0, 1'b1, t1);
      issue(k, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 1'b1, t1);
    end

    // Wait-state timing on the 2-wait instance.
    repeat (4) @(posedge clk); #1;
    issue(1, 1'b1, 32'h24, $urandom, 2'd2, 1'b0, 1'b1, t1);
    @(negedge clk); chk("dut1_ready_t1", 32'(req_ready[1]), 32'd0);
    @(negedge clk); chk("dut1_ready_t2", 32'(req_ready[1]), 32'd0);
    @(posedge clk); #1;
    issue(1, 1'b0, 32'h24, 32'd0, 2'd2, 1'b0, 1'b1, t2);
    chk("dut1_next_accept", t2, t1 + 3);
    repeat (4) @(posedge clk); #1;

    // Reset while a store is waiting: it must neither respond nor commit.
    issue(1, 1'b1, 32'h20, 32'hCAFEBABE, 2'd2, 1'b0, 1'b0, t1);
    rst[1] = 1'b1;
    @(negedge clk); chk("dut1_midrst_ready", 32'(req_ready[1]), 32'd0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("dut1_no_resp_after_rst", 32'(resp_valid[1]), 32'd0);
    end
    @(posedge clk); #1;
    issue(1, 1'b0, 32'h20, 32'd0, 2'd2, 1'b0, 1'b1, t1);

    for (int k = 0; k < NDUT; k++) begin
      for (int n = 0; n < 150; n++) begin
        w = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        a = 32'($urandom_range(0, 63));
        if (w != 2'd3 && $urandom_range(0, 3) != 0) a = a - (a % (32'd1 << w));
        if ($urandom_range(0, 9) == 0) a = ($urandom | 32'h1000) & 32'hFFFFFFFC;
        issue(k, 1'($urandom_range(0, 1)), a, $urandom, w, 1'($urandom_range(0, 1)), 1'b1, t1);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
    end

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("dut0_queue_drained", q0.size(), 32'd0);
    chk("dut1_queue_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Data-memory responder that services the load/store requests the core's MEM stage issues: accepts one request per valid/ready handshake, performs width and alignment checks, and reads or writes a word-organised, byte-lane-writable RAM. It returns read data or a 3-bit memory exception code after a configurable number of wait states. It sits outside the core on the data side; its `resp_exception` encoding matches the 3-bit memory exception field the regwrite stage folds into the final exception vector.

## Interface
Parameters:
- `ADDR_BITS`, default 10: word-address width; RAM holds 2**ADDR_BITS 32-bit words.
- `WAIT_CYCLES`, default 0: extra cycles between acceptance and response; legal range 0..3.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_width`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_zext`  in  1  load zero-extends when 1, sign-extends when 0; ignored for word and stores.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  load result, right-aligned and extended; 0 for stores and faults.
- `resp_exception`  out  3  0 = none, 1 = misaligned, 2 = out of range, 3 = illegal width.

## Operation
- FSM states: IDLE, WAIT, RESP.
- `req_ready` = 1 in IDLE and RESP; 0 in WAIT and whenever `rst` = 1.
- Accept when `req_valid & req_ready`. Latch write, addr, wdata, width, zext. Load a wait counter with `WAIT_CYCLES`.
- Accept transitions:
  - WAIT_CYCLES = 0: go to RESP.
  - Otherwise: go to WAIT.
- WAIT: decrement the counter each cycle; go to RESP on the edge where the counter reaches 0.
- RESP leaves after one cycle:
  - To IDLE if there is no accept that cycle.
  - Otherwise to RESP or WAIT per the accept rules above. Back-to-back requests are allowed.
- Fault check on latched request, first match wins:
  - width 3 → 3.
  - Half with addr[0] = 1, or word with addr[1:0] ≠ 0 → 1.
  - addr[31:2] ≥ 2**ADDR_BITS → 2.
- A faulted request never touches the RAM and returns rdata 0.
- Lanes are little-endian.
  - Byte: lane addr[1:0].
  - Half: lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
- Store commits on the edge that raises `resp_valid`: only the selected lanes are written, from replicated wdata.
- Load samples the RAM on that same edge. A load immediately following a store to the same word therefore sees the stored data.
- Read extraction:
  - Byte and half are extended from bit 7 or 15 per `req_zext`.
  - Word is returned unchanged.
- RAM contents are not cleared by reset.

## Timing
- Reset values:
  - state IDLE, `resp_valid` 0, `resp_rdata` 0, `resp_exception` 0, wait counter 0.
  - `req_ready` reads 0 during reset and 1 in the first cycle after.
- Latency: request accepted in cycle T → `resp_valid` high in cycle T+1+WAIT_CYCLES, for exactly one cycle.
- `resp_rdata` and `resp_exception` are valid only while `resp_valid` = 1. They are held at 0 otherwise.
- Throughput:
  - WAIT_CYCLES = 0: one request per cycle sustained.
  - Otherwise: one per WAIT_CYCLES+1 cycles.
- Reset asserted in WAIT or RESP drops the pending request. No response is produced, and a pending store is not committed if reset precedes its commit edge.
- `req_valid` while `req_ready` = 0 is ignored. The initiator must hold the request.
- Simultaneous response and new accept in RESP is legal. The new request's response follows per the latency rule, with no bubble when WAIT_CYCLES = 0.

## Test plan
- Reset, then word store 0xDEADBEEF to 0x10, then word load 0x10 (WAIT_CYCLES = 0, back-to-back).
  - Responses in consecutive cycles.
  - Load returns 0xDEADBEEF, exception 0.
- Byte loads from 0x10–0x13, after the word store above:
  - zext = 0 → 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFAD, 0xFFFFFFDE.
  - zext = 1 → 0xEF, 0xBE, 0xAD, 0xDE.
- Half store 0x1234 to 0x12, then word load 0x10 → 0x1234BEEF.
- Faults, each returning rdata 0 with the word at 0x10 unchanged afterward:
  - Word load at 0x11 → exception 1.
  - Width 3 at 0x11 → exception 3 (priority over misalignment).
  - Word load at (1<<ADDR_BITS)*4 → exception 2.
- WAIT_CYCLES = 2, accept at cycle T:
  - `req_ready` = 0 in T+1 and T+2.
  - `resp_valid` high only in T+3.
  - Accept in T+3 responds in T+6.
- WAIT_CYCLES = 2, store 0xCAFEBABE to 0x20 with reset asserted in T+1:
  - No `resp_valid`.
  - A subsequent load from 0x20 returns its prior contents.
